// File: rtl/serin_pkg.sv
// Shared types and helpers for the POKEY serial-input receiver.
// Holds the FSM state encoding, counter sizing and the parity check.
package serin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } serin_state_e;

    localparam int unsigned MAX_DATA_BITS = 9;
    localparam int unsigned MAX_STOP_BITS = 2;

    // Counter must hold the larger of the data-bit and stop-bit indices.
    function automatic int unsigned cnt_width(input int unsigned data_bits,
                                              input int unsigned stop_bits);
        int unsigned m;
        m = (data_bits > stop_bits) ? data_bits : stop_bits;
        return $clog2(m + 1);
    endfunction

    localparam int unsigned CNT_W_MAX = cnt_width(MAX_DATA_BITS, MAX_STOP_BITS);

    // True when data plus parity bit disagree with the selected sense.
    function automatic logic parity_error(input logic [MAX_DATA_BITS-1:0] data,
                                          input logic                     par_bit,
                                          input logic                     odd);
        return ((^data) ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/serin_receiver_if.sv
// SID-side handshake and SERIN/SKSTAT result bundle of the serial receiver.
// The receiver is the slave; the register/CPU side is the master.
interface serin_receiver_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic                 sdi;
    logic                 bitTick;
    logic                 rxReadAck;
    logic                 skresClr;
    logic                 startDetect;
    logic [DATA_BITS-1:0] serinData;
    logic                 dataReady;
    logic                 serinIrq;
    logic                 sdiBusy;
    logic                 framingErr;
    logic                 overrunErr;
    logic                 parityErr;

    modport master (
        output sdi, bitTick, rxReadAck, skresClr,
        input  startDetect, serinData, dataReady, serinIrq, sdiBusy,
               framingErr, overrunErr, parityErr
    );

    modport slave (
        input  sdi, bitTick, rxReadAck, skresClr,
        output startDetect, serinData, dataReady, serinIrq, sdiBusy,
               framingErr, overrunErr, parityErr
    );

endinterface

// File: rtl/serin_shift_reg.sv
// LSB-first receive shift register: each new bit enters at the MSB so the
// first bit of the frame ends up in bit 0 after WIDTH shifts.
module serin_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (shift_en_i) begin
            data_q <= {bit_i, data_q[WIDTH-1:1]};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/serin_receiver.sv
// Parametrised SERIN receive state machine: start/data/parity/stop decode,
// SERIN data capture and the latched framing, overrun and parity errors.
module serin_receiver
    import serin_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    serin_receiver_if.slave        bus
);

    localparam int unsigned CNT_W = cnt_width(DATA_BITS, STOP_BITS);

    serin_state_e         state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sdi_prev_q;
    logic                 fe_pend_q;
    logic                 pe_pend_q;
    logic                 start_detect_q;
    logic                 serin_irq_q;
    logic                 busy_q;
    logic                 data_ready_q;
    logic [DATA_BITS-1:0] serin_data_q;
    logic                 framing_err_q;
    logic                 overrun_err_q;
    logic                 parity_err_q;

    logic                 sdi;
    logic                 tick;
    logic                 last_data;
    logic                 last_stop;
    logic                 fe_now;
    logic                 shift_clr;
    logic                 shift_en;
    logic [DATA_BITS-1:0] shift_data;

    assign sdi       = bus.sdi;
    assign tick      = bus.bitTick;
    assign last_data = (cnt_q == CNT_W'(DATA_BITS - 1));
    assign last_stop = (cnt_q == CNT_W'(STOP_BITS - 1));
    assign fe_now    = fe_pend_q | ~sdi;
    assign shift_clr = (state_q == ST_START) && tick && !sdi;
    assign shift_en  = (state_q == ST_DATA) && tick;

    serin_shift_reg #(
        .WIDTH (DATA_BITS)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (shift_clr),
        .shift_en_i (shift_en),
        .bit_i      (sdi),
        .data_o     (shift_data)
    );

    // Later assignments in this block take priority: frame completion
    // overrides rxReadAck, and error setting overrides skresClr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            sdi_prev_q     <= 1'b1;
            fe_pend_q      <= 1'b0;
            pe_pend_q      <= 1'b0;
            start_detect_q <= 1'b0;
            serin_irq_q    <= 1'b0;
            busy_q         <= 1'b0;
            data_ready_q   <= 1'b0;
            serin_data_q   <= '0;
            framing_err_q  <= 1'b0;
            overrun_err_q  <= 1'b0;
            parity_err_q   <= 1'b0;
        end else begin
            start_detect_q <= 1'b0;
            serin_irq_q    <= 1'b0;
            sdi_prev_q     <= sdi;

            if (bus.rxReadAck) begin
                data_ready_q <= 1'b0;
            end
            if (bus.skresClr) begin
                framing_err_q <= 1'b0;
                overrun_err_q <= 1'b0;
                parity_err_q  <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (sdi_prev_q && !sdi) begin
                        state_q        <= ST_START;
                        start_detect_q <= 1'b1;
                        busy_q         <= 1'b1;
                        cnt_q          <= '0;
                        fe_pend_q      <= 1'b0;
                        pe_pend_q      <= 1'b0;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        cnt_q <= '0;
                        if (!sdi) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (last_data) begin
                            cnt_q   <= '0;
                            state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        pe_pend_q <= parity_error(MAX_DATA_BITS'(shift_data), sdi,
                                                  PARITY_ODD);
                        cnt_q     <= '0;
                        state_q   <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (!sdi) begin
                            fe_pend_q <= 1'b1;
                        end
                        if (last_stop) begin
                            state_q      <= ST_IDLE;
                            busy_q       <= 1'b0;
                            cnt_q        <= '0;
                            serin_data_q <= shift_data;
                            data_ready_q <= 1'b1;
                            serin_irq_q  <= 1'b1;
                            if (fe_now) begin
                                framing_err_q <= 1'b1;
                            end
                            if (pe_pend_q) begin
                                parity_err_q <= 1'b1;
                            end
                            if (data_ready_q && !bus.rxReadAck) begin
                                overrun_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.startDetect = start_detect_q;
    assign bus.serinData   = serin_data_q;
    assign bus.dataReady   = data_ready_q;
    assign bus.serinIrq    = serin_irq_q;
    assign bus.sdiBusy     = busy_q;
    assign bus.framingErr  = framing_err_q;
    assign bus.overrunErr  = overrun_err_q;
    assign bus.parityErr   = parity_err_q;

endmodule

// File: tb/tb_serin_receiver.sv
// Bench for serin_receiver: an 8N1 instance and a 7-bit even-parity,
// two-stop-bit instance, checked against a frame-level reference model.
module tb_serin_receiver;

    logic clk = 1'b0;
    logic reset;
    logic sdi, tick, ack, clr;
    int   sel;

    always #5 clk = ~clk;

    serin_receiver_if #(.DATA_BITS(8)) bus0 ();
    serin_receiver_if #(.DATA_BITS(7)) bus1 ();

    // Only the selected instance sees activity; the other idles high.
    assign bus0.sdi       = (sel == 0) ? sdi : 1'b1;
    assign bus0.bitTick   = (sel == 0) && tick;
    assign bus0.rxReadAck = (sel == 0) && ack;
    assign bus0.skresClr  = (sel == 0) && clr;
    assign bus1.sdi       = (sel == 1) ? sdi : 1'b1;
    assign bus1.bitTick   = (sel == 1) && tick;
    assign bus1.rxReadAck = (sel == 1) && ack;
    assign bus1.skresClr  = (sel == 1) && clr;

    serin_receiver #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    serin_receiver #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
        dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] m_data [2];
    logic       m_rdy  [2];
    logic       m_fe   [2];
    logic       m_oe   [2];
    logic       m_pe   [2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input int s, input logic e_sd, input logic e_irq,
                               input logic e_busy);
        logic [8:0] od;
        logic       sd, irq, busy, rdy, fe, oe, pe;
        if (s == 0) begin
            od = 9'(bus0.serinData); sd = bus0.startDetect; irq = bus0.serinIrq;
            busy = bus0.sdiBusy; rdy = bus0.dataReady; fe = bus0.framingErr;
            oe = bus0.overrunErr; pe = bus0.parityErr;
        end else begin
            od = 9'(bus1.serinData); sd = bus1.startDetect; irq = bus1.serinIrq;
            busy = bus1.sdiBusy; rdy = bus1.dataReady; fe = bus1.framingErr;
            oe = bus1.overrunErr; pe = bus1.parityErr;
        end
        chk($sformatf("d%0d.serinData", s),   16'(od),   16'(m_data[s]));
        chk($sformatf("d%0d.startDetect", s), 16'(sd),   16'(e_sd));
        chk($sformatf("d%0d.serinIrq", s),    16'(irq),  16'(e_irq));
        chk($sformatf("d%0d.sdiBusy", s),     16'(busy), 16'(e_busy));
        chk($sformatf("d%0d.dataReady", s),   16'(rdy),  16'(m_rdy[s]));
        chk($sformatf("d%0d.framingErr", s),  16'(fe),   16'(m_fe[s]));
        chk($sformatf("d%0d.overrunErr", s),  16'(oe),   16'(m_oe[s]));
        chk($sformatf("d%0d.parityErr", s),   16'(pe),   16'(m_pe[s]));
    endtask

    // All helpers start and end at a falling clock edge.
    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            sdi = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic do_tick(input logic b);
        sdi  = b;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic start_edge(input int s);
        sel = s;
        sdi = 1'b1;
        @(negedge clk);
        sdi = 1'b0;
        @(negedge clk);
        check_state(s, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic send_frame(input int s, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops, input logic ack_done);
        int         nb;
        int         ns;
        logic [8:0] d;
        logic       fe;
        logic       pe;
        nb = (s == 0) ? 8 : 7;
        ns = (s == 0) ? 1 : 2;
        start_edge(s);
        gap();
        do_tick(1'b0);
        check_state(s, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < nb; i++) begin
            gap();
            do_tick(data[i]);
        end
        if (s == 1) begin
            gap();
            do_tick(pbit);
        end
        for (int j = 0; j < ns; j++) begin
            gap();
            if (j == ns - 1) ack = ack_done;
            do_tick(stops[j]);
        end
        ack = 1'b0;
        sdi = 1'b1;
        d  = data & 9'((1 << nb) - 1);
        fe = 1'b0;
        for (int j = 0; j < ns; j++) if (!stops[j]) fe = 1'b1;
        pe = (s == 1) && ((($countones(d) + int'(pbit)) % 2) != 0);
        m_oe[s]   = m_oe[s] | (m_rdy[s] & ~ack_done);
        m_rdy[s]  = 1'b1;
        m_data[s] = d;
        m_fe[s]   = m_fe[s] | fe;
        m_pe[s]   = m_pe[s] | pe;
        check_state(s, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_state(s, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_ack(input int s);
        sel = s;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_rdy[s] = 1'b0;
        check_state(s, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_errs(input int s);
        sel = s;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_fe[s] = 1'b0;
        m_oe[s] = 1'b0;
        m_pe[s] = 1'b0;
        check_state(s, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_data[s] = '0; m_rdy[s] = 1'b0;
            m_fe[s] = 1'b0; m_oe[s] = 1'b0; m_pe[s] = 1'b0;
        end
    endtask

    initial begin
        int         s;
        logic [1:0] stops;
        reset = 1'b1; sdi = 1'b1; tick = 1'b0; ack = 1'b0; clr = 1'b0; sel = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state(0, 1'b0, 1'b0, 1'b0);
        check_state(1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Clean 8N1 frame
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0);

        // False start: start bit sampled high
        start_edge(0);
        do_tick(1'b1);
        check_state(0, 1'b0, 1'b0, 1'b0);
        read_ack(0);

        // Framing error then SKRES clear
        send_frame(0, 9'h03C, 1'b0, 2'b10, 1'b0);
        clear_errs(0);
        read_ack(0);

        // Overrun, then completion with simultaneous read
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0);
        clear_errs(0);
        send_frame(0, 9'h033, 1'b0, 2'b11, 1'b1);

        // 7E2: bad and good parity, then bad second stop bit
        send_frame(1, 9'h041, 1'b1, 2'b11, 1'b0);
        clear_errs(1);
        read_ack(1);
        send_frame(1, 9'h041, 1'b0, 2'b11, 1'b0);
        read_ack(1);
        send_frame(1, 9'h05A, 1'b0, 2'b01, 1'b0);
        clear_errs(1);

        // Reset after four data bits
        start_edge(0);
        do_tick(1'b0);
        for (int i = 0; i < 4; i++) do_tick(1'($urandom));
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_state(0, 1'b0, 1'b0, 1'b0);
        check_state(1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        sdi   = 1'b1;
        @(negedge clk);
        send_frame(0, 9'h055, 1'b0, 2'b11, 1'b0);

        // Randomised frames
        for (int k = 0; k < 24; k++) begin
            s     = int'($urandom_range(0, 1));
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send_frame(s, 9'($urandom), 1'($urandom), stops, 1'($urandom));
            if ($urandom_range(0, 1) == 1) read_ack(s);
            if ($urandom_range(0, 3) == 0) clear_errs(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serin_receiver.md
# serin_receiver

Parametrised serial-input receiver for the POKEY SERIN/SKSTAT path. It replaces the fixed 8N1 start/stop decode with a full receive state machine. Data width, stop-bit count and optional parity are configurable, and overrun and parity errors are latched alongside framing errors. It sits between the synchronised SID pin and the SERIN/SKSTAT/IRQST register logic, clocked by the bit-rate enable from the channel-4 timer.

## Interface
- DATA_BITS, 8: data bits per frame (5–9), LSB first.
- STOP_BITS, 1: stop bits checked (1 or 2).
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- sdi, in, 1: serial data, already synchronised to clk; idle high.
- bitTick, in, 1: one-cycle enable at each mid-bit sample point.
- rxReadAck, in, 1: CPU read of SERIN; clears dataReady.
- skresClr, in, 1: SKRES write; clears framing, overrun and parity latches.
- startDetect, out, 1: one-cycle pulse on a valid idle-to-start falling edge; restarts the channel timer in async mode.
- serinData, out, DATA_BITS: last received data word.
- dataReady, out, 1: level, set on frame completion.
- serinIrq, out, 1: one-cycle pulse on frame completion.
- sdiBusy, out, 1: high whenever the FSM is not IDLE.
- framingErr, out, 1: latched error.
- overrunErr, out, 1: latched error.
- parityErr, out, 1: latched error.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge on sdi (previous registered sample 1, current 0) pulses startDetect and moves the FSM to START.
- START: on bitTick, sdi=0 → DATA with the bit counter cleared; sdi=1 → IDLE as a false start (no flags, no IRQ).
- DATA: on each bitTick, shift sdi in at the MSB of a DATA_BITS register (LSB-first frame). After DATA_BITS ticks, go to PARITY if PARITY_EN, else STOP.
- PARITY: on bitTick, compute the XOR of the data bits and the received parity bit. An error exists when that XOR ≠ PARITY_ODD. Go to STOP.
- STOP: on each bitTick, a sampled 0 sets a pending framing error. After STOP_BITS ticks, the frame completes and the FSM returns to IDLE.
- Frame completion does the following:
  - serinData ← shift register, even if the frame has errors.
  - dataReady ← 1 and serinIrq pulses.
  - Pending framing/parity errors are ORed into their latches.
  - If dataReady was already 1 and rxReadAck is not asserted in the same cycle, overrunErr ← 1.
- Same-cycle priority:
  - Completion beats rxReadAck: dataReady stays 1 and no overrun is flagged.
  - An error being set beats skresClr.
- bitTick is ignored in IDLE. While busy, sdi edges are ignored outside tick cycles.
- A new start edge can be accepted in the cycle after the return to IDLE.

## Timing
- Reset values:
  - FSM = IDLE; all counters and the shift register = 0.
  - serinData = 0; dataReady, serinIrq, startDetect, sdiBusy = 0.
  - All three error latches = 0.
  - Edge-detect register = 1, so no false start is seen out of reset.
- Reset mid-frame aborts the frame immediately: no IRQ, no data update.
- startDetect is asserted the cycle after the falling edge is registered. sdiBusy rises in the same cycle.
- Completion outputs (serinData, dataReady, serinIrq, error latches) update on the clock edge that follows the final stop-bit bitTick cycle. They are visible one cycle after that tick.
- sdiBusy falls in the same cycle that completion outputs appear.
- rxReadAck/skresClr take effect on the next clock edge.

## Structure
- Package serin_pkg:
  - state enum (3-bit encoding).
  - parity function: XOR reduction with an odd/even select.
  - localparam for the counter width: $clog2(max(DATA_BITS, STOP_BITS)+1).
- One natural sub-module, serin_shift_reg: a DATA_BITS-wide LSB-first shift register with shift enable and synchronous clear.
- The FSM, counters and flag latches live in serin_receiver.

## Test plan
- Default 8N1, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → serinData=0xA5, one serinIrq pulse, dataReady=1, no errors.
- Start bit sampled 1 on its bitTick (glitch) → back to IDLE, sdiBusy drops, no IRQ, dataReady unchanged.
- Stop bit 0 on 0x3C → serinData=0x3C, framingErr=1. skresClr → framingErr=0; dataReady unaffected.
- Two frames 0x11, 0x22 with no rxReadAck → serinData=0x22, overrunErr=1. Repeat with rxReadAck in the completion cycle → overrunErr stays 0.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0: data 0x41 with parity bit 1 → parityErr=1. Same data with parity bit 0 → no error.
- Assert reset during DATA after 4 bits → all outputs at reset values. A following clean 0x55 frame is received correctly.
